// File: rtl/traffic_monitor_if.sv
// ============================================================================
// Module      : traffic_monitor_if
// Description : Observed light bus plus the checker's status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface traffic_monitor_if;
    logic [1:0]  light;
    logic [1:0]  phase;
    logic        locked;
    logic        err_seq;
    logic        err_dwell;
    logic        err_code;
    logic        err_sticky;
    logic [7:0]  err_count;
    logic [15:0] cycle_count;

    // Controller / bench side: drives light, observes status.
    modport master (
        output light,
        input  phase, locked, err_seq, err_dwell, err_code,
        input  err_sticky, err_count, cycle_count
    );

    // Monitor side.
    modport slave (
        input  light,
        output phase, locked, err_seq, err_dwell, err_code,
        output err_sticky, err_count, cycle_count
    );
endinterface

`default_nettype wire

// File: rtl/traffic_monitor.sv
// ============================================================================
// Module      : traffic_monitor
// Description : Passive checker of light phase order and per-phase dwell time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_monitor #(
    parameter int RED_TIME    = 10,
    parameter int YELLOW_TIME = 10,
    parameter int GREEN_TIME  = 10,
    parameter int CNT_W       = 6
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    traffic_monitor_if.slave   bus
);

    localparam logic [1:0]       c_red      = 2'b00;
    localparam logic [1:0]       c_yellow   = 2'b01;
    localparam logic [1:0]       c_green    = 2'b10;
    localparam logic [1:0]       c_bad      = 2'b11;
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero     = '0;
    localparam logic [CNT_W-1:0] c_dwell_mx = '1;
    localparam logic [CNT_W-1:0] c_red_t    = CNT_W'(RED_TIME);
    localparam logic [CNT_W-1:0] c_yellow_t = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] c_green_t  = CNT_W'(GREEN_TIME);

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_prev, w_prev_nxt;
    logic [CNT_W-1:0] r_dwell, w_dwell_nxt, w_dwell_inc, w_time;
    logic [1:0]       w_succ;
    logic             w_seq, w_dwl, w_code, w_cyc, w_any;

    logic             r_err_seq, r_err_dwell, r_err_code, r_err_sticky;
    logic [7:0]       r_err_count;
    logic [15:0]      r_cycle_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= SYNC;
            r_prev        <= c_red;
            r_dwell       <= c_zero;
            r_err_seq     <= 1'b0;
            r_err_dwell   <= 1'b0;
            r_err_code    <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_err_count   <= 8'd0;
            r_cycle_count <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_dwell     <= w_dwell_nxt;
            r_err_seq   <= w_seq;
            r_err_dwell <= w_dwl;
            r_err_code  <= w_code;
            if (w_any) begin
                r_err_sticky <= 1'b1;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
            if (w_cyc) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_dwell_nxt = r_dwell;
        w_seq       = 1'b0;
        w_dwl       = 1'b0;
        w_code      = 1'b0;
        w_cyc       = 1'b0;
        w_dwell_inc = (r_dwell == c_dwell_mx) ? r_dwell : r_dwell + c_one;

        case (r_prev)
            c_red:    begin w_time = c_red_t;    w_succ = c_green;  end
            c_green:  begin w_time = c_green_t;  w_succ = c_yellow; end
            default:  begin w_time = c_yellow_t; w_succ = c_red;    end
        endcase

        if (bus.light == c_bad) begin
            w_code      = 1'b1;
            w_state_nxt = SYNC;
            w_dwell_nxt = c_zero;
        end else if (bus.light == r_prev) begin
            w_dwell_nxt = w_dwell_inc;
            // Saturated counter must not re-fire when T+1 equals all-ones.
            if (r_state == TRACK && r_dwell != c_dwell_mx &&
                w_dwell_inc == w_time + c_one) begin
                w_dwl = 1'b1;
            end
        end else if (r_state == SYNC) begin
            w_prev_nxt  = bus.light;
            w_dwell_nxt = c_one;
            // A zero dwell marks the unmeasured first segment after reset.
            if (r_dwell != c_zero) begin
                w_state_nxt = TRACK;
            end
        end else begin
            w_seq       = (bus.light != w_succ);
            w_dwl       = (r_dwell < w_time);
            w_cyc       = (r_prev == c_yellow) && (bus.light == c_red) &&
                          (r_dwell == w_time);
            w_prev_nxt  = bus.light;
            w_dwell_nxt = c_one;
        end
    end

    assign w_any = w_seq | w_dwl | w_code;

    assign bus.phase       = r_prev;
    assign bus.locked      = (r_state == TRACK);
    assign bus.err_seq     = r_err_seq;
    assign bus.err_dwell   = r_err_dwell;
    assign bus.err_code    = r_err_code;
    assign bus.err_sticky  = r_err_sticky;
    assign bus.err_count   = r_err_count;
    assign bus.cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_traffic_monitor.sv
// ============================================================================
// Module      : tb_traffic_monitor
// Description : Directed self-checking bench for traffic_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_monitor;

    localparam logic [1:0] c_r = 2'b00;
    localparam logic [1:0] c_y = 2'b01;
    localparam logic [1:0] c_g = 2'b10;
    localparam logic [1:0] c_x = 2'b11;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;
    int   pulses;

    traffic_monitor_if mon ();

    traffic_monitor #(
        .RED_TIME    (10),
        .YELLOW_TIME (10),
        .GREEN_TIME  (10),
        .CNT_W       (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample; return just after the edge that captured it.
    task automatic step(input logic [1:0] l);
        mon.light = l;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"},   32'(mon.phase), 0);
        chk({tag, "_locked"},  32'(mon.locked), 0);
        chk({tag, "_eseq"},    32'(mon.err_seq), 0);
        chk({tag, "_edwell"},  32'(mon.err_dwell), 0);
        chk({tag, "_ecode"},   32'(mon.err_code), 0);
        chk({tag, "_sticky"},  32'(mon.err_sticky), 0);
        chk({tag, "_ecount"},  32'(mon.err_count), 0);
        chk({tag, "_cycles"},  32'(mon.cycle_count), 0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        mon.light = c_r;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Legal run: four full R/G/Y rounds plus the closing R.
        run(c_r, 10);
        chk("legal_unlocked", 32'(mon.locked), 0);
        step(c_g);
        chk("legal_lock_on_g", 32'(mon.locked), 1);
        run(c_g, 9);
        run(c_y, 10);
        for (int k = 0; k < 3; k++) begin
            run(c_r, 10);
            run(c_g, 10);
            run(c_y, 10);
        end
        step(c_r);
        chk("legal_cycles", 32'(mon.cycle_count), 4);
        chk("legal_ecount", 32'(mon.err_count), 0);
        chk("legal_sticky", 32'(mon.err_sticky), 0);
        chk("legal_phase",  32'(mon.phase), 0);

        // Short GREEN.
        run(c_r, 9);
        run(c_g, 9);
        step(c_y);
        chk("short_edwell", 32'(mon.err_dwell), 1);
        chk("short_eseq",   32'(mon.err_seq), 0);
        chk("short_ecount", 32'(mon.err_count), 1);
        chk("short_sticky", 32'(mon.err_sticky), 1);
        chk("short_phase",  32'(mon.phase), 1);
        step(c_y);
        chk("short_pulse_one_wide", 32'(mon.err_dwell), 0);
        run(c_y, 8);
        step(c_r);
        chk("short_cycles", 32'(mon.cycle_count), 5);

        // Long RED: 12 samples in total.
        run(c_r, 9);
        chk("long_before", 32'(mon.err_dwell), 0);
        step(c_r);
        chk("long_11th", 32'(mon.err_dwell), 1);
        step(c_r);
        chk("long_12th", 32'(mon.err_dwell), 0);
        step(c_g);
        chk("long_change_edwell", 32'(mon.err_dwell), 0);
        chk("long_ecount", 32'(mon.err_count), 2);
        run(c_g, 9);
        run(c_y, 10);
        step(c_r);
        chk("long_cycles", 32'(mon.cycle_count), 6);

        // Illegal order R -> Y.
        run(c_r, 9);
        step(c_y);
        chk("order_eseq",   32'(mon.err_seq), 1);
        chk("order_edwell", 32'(mon.err_dwell), 0);
        chk("order_phase",  32'(mon.phase), 1);
        chk("order_locked", 32'(mon.locked), 1);
        chk("order_ecount", 32'(mon.err_count), 3);
        run(c_y, 9);
        step(c_r);
        chk("order_yr_eseq", 32'(mon.err_seq), 0);

        // Illegal code, then resume.
        run(c_r, 9);
        step(c_x);
        chk("code_ecode",  32'(mon.err_code), 1);
        chk("code_locked", 32'(mon.locked), 0);
        chk("code_phase",  32'(mon.phase), 0);
        chk("code_ecount", 32'(mon.err_count), 4);
        run(c_g, 10);
        chk("code_clear", 32'(mon.err_code), 0);
        step(c_y);
        chk("code_relock", 32'(mon.locked), 1);
        chk("code_edwell", 32'(mon.err_dwell), 0);
        run(c_y, 9);
        step(c_r);
        chk("code_resume_ecount", 32'(mon.err_count), 4);

        // Asynchronous reset in the middle of GREEN.
        run(c_r, 9);
        run(c_g, 5);
        chk("rst_pre_sticky", 32'(mon.err_sticky), 1);
        reset_n = 1'b0;
        #2;
        chk_all_zero("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run(c_g, 4);
        run(c_y, 10);
        step(c_r);
        chk("rst_locked", 32'(mon.locked), 1);
        chk("rst_ecount", 32'(mon.err_count), 0);
        chk("rst_sticky", 32'(mon.err_sticky), 0);
        chk("rst_cycles", 32'(mon.cycle_count), 1);

        // Stuck RED: exactly one long-dwell pulse despite saturation.
        pulses = 0;
        for (int i = 0; i < 79; i++) begin
            step(c_r);
            if (mon.err_dwell === 1'b1) pulses++;
        end
        chk("stuck_pulses", 32'(pulses), 1);
        chk("stuck_ecount", 32'(mon.err_count), 1);

        // Consecutive bad codes and err_count saturation.
        step(c_x);
        step(c_x);
        chk("sat_consecutive", 32'(mon.err_code), 1);
        run(c_x, 258);
        chk("sat_ecount", 32'(mon.err_count), 255);
        chk("sat_ecode",  32'(mon.err_code), 1);
        chk("sat_locked", 32'(mon.locked), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
